// File: rtl/ethernet_frame_fifo.sv
// ethernet_frame_fifo: store-and-forward 8-bit AXIS frame FIFO; overflowed frames are dropped, ETHERNET_FRAME_FIFO_DROP_BAD_FRAME_EN also drops tuser-flagged frames
module ethernet_frame_fifo #(
  parameter int DEPTH              = 2048,
  parameter int ALMOST_FULL_MARGIN = 1536
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        fifo_is_almost_full,
  output logic [15:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_st_e;
  wr_st_e st_q, st_d;
  logic [AW:0] wr_q, wr_d, commit_q, commit_d, rd_q, rd_d, used, free_d;
  logic [9:0] mem [DEPTH];
  logic [9:0] a_q, m_q;
  logic a_v_q, m_v_q, af_q, fetch, adv, acc, full, we, drop, bad;
  logic [15:0] drop_q;
  assign s_axis_tready = rstn;
  assign acc = s_axis_tvalid & s_axis_tready;
  assign used = wr_q - rd_q;
  assign full = used == DEPTH_P;
`ifdef ETHERNET_FRAME_FIFO_DROP_BAD_FRAME_EN
  assign bad = s_axis_tuser;
`else
  assign bad = 1'b0;
`endif
  assign we = acc & ~full & (st_q != WR_DROP);
  assign adv = a_v_q & (~m_v_q | m_axis_tready);
  assign fetch = (rd_q != commit_q) & (~a_v_q | adv);
  assign rd_d = rd_q + {{AW{1'b0}}, fetch};
  assign free_d = DEPTH_P - (wr_d - rd_d);
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_q;
  assign m_axis_tvalid = m_v_q;
  assign fifo_is_almost_full = af_q;
  assign drop_count = drop_q;
  // write FSM next state: speculative write, commit on tlast, rewind on overflow or bad frame
  always_comb begin
    wr_d = wr_q;
    commit_d = commit_q;
    st_d = st_q;
    drop = 1'b0;
    if (acc) begin
      if (st_q == WR_DROP) st_d = s_axis_tlast ? WR_IDLE : WR_DROP;
      else if (full) begin
        wr_d = commit_q;
        drop = 1'b1;
        st_d = s_axis_tlast ? WR_IDLE : WR_DROP;
      end else if (s_axis_tlast & bad) begin
        wr_d = commit_q;
        drop = 1'b1;
        st_d = WR_IDLE;
      end else if (s_axis_tlast) begin
        wr_d = wr_q + ONE;
        commit_d = wr_q + ONE;
        st_d = WR_IDLE;
      end else begin
        wr_d = wr_q + ONE;
        st_d = WR_FRAME;
      end
    end
  end
  // pointer, FSM, almost-full and drop counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q <= WR_IDLE;
      wr_q <= '0;
      commit_q <= '0;
      rd_q <= '0;
      af_q <= 1'b0;
      drop_q <= '0;
    end else begin
      st_q <= st_d;
      wr_q <= wr_d;
      commit_q <= commit_d;
      rd_q <= rd_d;
      af_q <= 32'(free_d) < ALMOST_FULL_MARGIN;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end
  // frame RAM with a registered read port feeding the output pipeline
  always_ff @(posedge clk) begin
    if (we) mem[wr_q[AW-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    if (fetch) a_q <= mem[rd_q[AW-1:0]];
  end
  // RAM-read stage and AXIS output register with hold under backpressure
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_v_q <= 1'b0;
      m_v_q <= 1'b0;
      m_q <= '0;
    end else begin
      if (fetch) a_v_q <= 1'b1;
      else if (adv) a_v_q <= 1'b0;
      if (adv) begin
        m_v_q <= 1'b1;
        m_q <= a_q;
      end else if (m_axis_tready) m_v_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ethernet_frame_fifo.sv
// tb_ethernet_frame_fifo: scoreboard bench with frame-level reference model for ethernet_frame_fifo
`timescale 1ns/1ps
module tb_ethernet_frame_fifo;
  localparam int DEPTH = 64;
  localparam int MARGIN = 40;
  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, s_tready;
  logic [7:0] m_tdata;
  logic m_tvalid, m_tlast, m_tuser, af;
  logic m_tready = 1'b0;
  logic [15:0] dcnt;
  int tests = 0, fails = 0, drops = 0, rdy_mode = 0;
  logic [9:0] sb [$];
  logic [9:0] mv, ev, hold_d;
  bit hold_v = 1'b0;

  ethernet_frame_fifo #(.DEPTH(DEPTH), .ALMOST_FULL_MARGIN(MARGIN)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .fifo_is_almost_full(af), .drop_count(dcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // downstream ready: 0 = stalled, 1 = always ready, 2 = random
  always @(posedge clk) begin
    #1;
    m_tready = rdy_mode == 0 ? 1'b0 : rdy_mode == 1 ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  // monitor: AXIS hold rule and in-order comparison against the scoreboard
  always @(negedge clk) begin
    mv = {m_tuser, m_tlast, m_tdata};
    if (m_tvalid && hold_v) chk("hold", int'(mv), int'(hold_d));
    hold_v = m_tvalid && !m_tready && rstn;
    hold_d = mv;
    if (m_tvalid && m_tready && rstn) begin
      if (sb.size() == 0) chk("unexpected_beat", int'(mv), 1024);
      else begin
        ev = sb.pop_front();
        chk("beat", int'(mv), int'(ev));
      end
    end
  end

  // reference model: a frame is stored whole iff it fits and is not a dropped bad frame
  task automatic send_frame(int len, bit user, int gap, logic [7:0] base);
    bit keep;
    int n;
    keep = len <= DEPTH;
`ifdef ETHERNET_FRAME_FIFO_DROP_BAD_FRAME_EN
    if (user) keep = 1'b0;
`endif
    if (keep) begin
      n = 0;
      while (sb.size() + len > DEPTH && n < 5000) begin
        tick();
        n++;
      end
      if (sb.size() + len > DEPTH) chk("fit_timeout", sb.size() + len, DEPTH);
      for (int i = 0; i < len; i++) sb.push_back({user && i == len - 1, i == len - 1, 8'(base + i)});
    end else drops++;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, gap)) begin
        s_tvalid = 1'b0;
        tick();
      end
      s_tvalid = 1'b1;
      s_tdata = 8'(base + i);
      s_tlast = i == len - 1;
      s_tuser = user && i == len - 1;
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    chk("drop_count", int'(dcnt), drops);
  endtask

  task automatic drain();
    int n;
    rdy_mode = 1;
    n = 0;
    while ((sb.size() != 0 || m_tvalid) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    rdy_mode = 0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    chk("rst_valid", int'(m_tvalid), 0);
    chk("rst_af", int'(af), 0);
    chk("rst_drop", int'(dcnt), 0);
    chk("rst_tready", int'(s_tready), 0);
    chk("rst_data", int'({m_tuser, m_tlast, m_tdata}), 0);
    sb.delete();
    drops = 0;
    rstn = 1'b1;
    tick();
    chk("tready", int'(s_tready), 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    rdy_mode = 1;
    tick();
    send_frame(64, 1'b0, 0, 8'd0);
    chk("lat_e0", int'(m_tvalid), 0);
    tick();
    chk("lat_e1", int'(m_tvalid), 0);
    tick();
    chk("lat_e2", int'(m_tvalid), 1);
    drain();
    rdy_mode = 0;
    send_frame(70, 1'b0, 0, 8'd100);
    repeat (4) tick();
    chk("ovf_absent", int'(m_tvalid), 0);
    send_frame(8, 1'b0, 0, 8'd200);
    drain();
    rdy_mode = 0;
    repeat (3) tick();
    chk("af_idle", int'(af), 0);
    for (int k = 1; k <= 30; k++) sb.push_back({1'b0, k == 30, 8'(k)});
    for (int k = 1; k <= 30; k++) begin
      s_tvalid = 1'b1;
      s_tdata = 8'(k);
      s_tlast = k == 30;
      tick();
      chk("af", int'(af), int'((DEPTH - k) < MARGIN));
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    drain();
    tick();
    chk("af_drained", int'(af), 0);
    rdy_mode = 1;
    send_frame(20, 1'b0, 0, 8'd50);
    repeat (3) tick();
    rdy_mode = 0;
    repeat (10) tick();
    chk("stall_valid", int'(m_tvalid), 1);
    drain();
    send_frame(20, 1'b1, 0, 8'h40);
    drain();
    rdy_mode = 2;
    for (int f = 0; f < 40; f++)
      send_frame(($urandom_range(0, 9) == 0) ? $urandom_range(65, 80) : $urandom_range(1, 40),
                 $urandom_range(0, 6) == 0, 2, 8'($urandom_range(0, 255)));
    drain();
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1'b1;
      s_tdata = 8'(i);
      s_tlast = 1'b0;
      tick();
    end
    do_reset();
    send_frame(12, 1'b0, 1, 8'd7);
    drain();
    rdy_mode = 2;
    send_frame(30, 1'b0, 0, 8'd90);
    repeat (8) tick();
    do_reset();
    chk("af_after_rst", int'(af), 0);
    send_frame(16, 1'b0, 0, 8'd33);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
